// File: rtl/small_hb_int.sv
// Halfband 1:2 interpolator, taps [A 0 B 0.5 B 0 A]; y0 lands 6 clocks after accept, y1 at 7.
// No backpressure: strobes closer than 2 clocks are dropped and latched in overrun.
module small_hb_int #(
    parameter int WIDTH  = 18,
    parameter     DEVICE = "SPARTAN6"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bypass,
    input  logic             run,
    input  logic             stb_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             stb_out,
    output logic [WIDTH-1:0] data_out,
    output logic             overrun
);

    localparam logic signed [17:0] COEFF_A = -18'sd10690;
    localparam logic signed [17:0] COEFF_B = 18'sd75809;

    localparam int RS = 34 - WIDTH;
    localparam logic signed [36:0] P_HALF    = 37'sd1 <<< (RS - 1);
    localparam logic signed [36:0] P_HALF_M1 = P_HALF - 37'sd1;
    localparam logic signed [36:0] Y_MAX     = (37'sd1 <<< (WIDTH - 1)) - 37'sd1;
    localparam logic signed [36:0] Y_MIN     = -(37'sd1 <<< (WIDTH - 1));

    localparam int XS = WIDTH - 17;

    logic signed [16:0]       xr;
    logic signed [16:0]       x0_q, x1_q, x2_q, x3_q, x0_d, x1_d, x2_d, x3_d;
    logic signed [WIDTH-1:0]  h0_q, h1_q, h0_d, h1_d;
    logic signed [17:0]       sa_q, sb_q, sa_d, sb_d;
    logic [4:0][WIDTH-1:0]    yc_q, yc_d;
    logic [5:0]               vld_q, vld_d;
    logic signed [17:0]       op_c, op_s;
    logic signed [35:0]       mult_d, mult_q;
    logic signed [35:0]       pa_q, pa_d, p_q, p_d;
    logic signed [36:0]       p_ext, p_sum, p_shr;
    logic signed [WIDTH-1:0]  y0;
    logic                     stb_out_q, stb_out_d;
    logic [WIDTH-1:0]         data_out_q, data_out_d;
    logic                     overrun_q, overrun_d;
    logic                     filt_on, acc;

    // Input rounding to 17 bits, ties away from zero; only the positive side can overflow.
    generate
        if (XS == 0) begin : g_xr_pass
            assign xr = $signed(data_in);
        end else begin : g_xr_round
            localparam logic signed [WIDTH:0] X_HALF    = {{WIDTH{1'b0}}, 1'b1} << (XS - 1);
            localparam logic signed [WIDTH:0] X_HALF_M1 = X_HALF - {{WIDTH{1'b0}}, 1'b1};
            localparam logic signed [WIDTH:0] X_MAX     = (WIDTH+1)'(65535);
            logic signed [WIDTH:0] x_ext, x_sum, x_shr;
            always_comb begin
                x_ext = {data_in[WIDTH-1], data_in};
                x_sum = x_ext + (x_ext[WIDTH] ? X_HALF_M1 : X_HALF);
                x_shr = x_sum >>> XS;
                xr    = (x_shr > X_MAX) ? 17'sd65535 : x_shr[16:0];
            end
        end
    endgenerate

    // DSP48A1 has a synchronous P-register reset; other targets keep the product register reset-free.
    generate
        if (DEVICE == "SPARTAN6") begin : g_mult_rst
            always_ff @(posedge clk) begin
                if (rst) mult_q <= '0;
                else     mult_q <= mult_d;
            end
        end else begin : g_mult_nrst
            always_ff @(posedge clk) begin
                mult_q <= mult_d;
            end
        end
    endgenerate

    always_comb begin
        filt_on = run && !bypass;
        acc     = filt_on && stb_in && !vld_q[0];

        x0_d = x0_q;
        x1_d = x1_q;
        x2_d = x2_q;
        x3_d = x3_q;
        h0_d = h0_q;
        h1_d = h1_q;
        if (acc) begin
            x0_d = xr;
            x1_d = x0_q;
            x2_d = x1_q;
            x3_d = x2_q;
            h1_d = h0_q;
            h0_d = $signed(data_in);
        end

        vld_d = {vld_q[4:0], acc} & {6{filt_on}};

        sa_d = sa_q;
        sb_d = sb_q;
        yc_d = {yc_q[3:0], yc_q[0]};
        if (vld_q[0]) begin
            sa_d    = {x0_q[16], x0_q} + {x3_q[16], x3_q};
            sb_d    = {x1_q[16], x1_q} + {x2_q[16], x2_q};
            yc_d[0] = h1_q;
        end

        // One multiplier: outer-tap product on the first cycle, inner-tap product on the next.
        op_c   = vld_q[1] ? COEFF_A : COEFF_B;
        op_s   = vld_q[1] ? sa_q : sb_q;
        mult_d = 36'(op_c) * 36'(op_s);

        pa_d = vld_q[2] ? mult_q : pa_q;
        p_d  = vld_q[3] ? (pa_q + mult_q) : p_q;

        p_ext = {p_q[35], p_q};
        p_sum = p_ext + (p_ext[36] ? P_HALF_M1 : P_HALF);
        p_shr = p_sum >>> RS;
        if (p_shr > Y_MAX)      y0 = Y_MAX[WIDTH-1:0];
        else if (p_shr < Y_MIN) y0 = Y_MIN[WIDTH-1:0];
        else                    y0 = p_shr[WIDTH-1:0];

        overrun_d = overrun_q;
        if (filt_on && stb_in && vld_q[0]) overrun_d = 1'b1;

        stb_out_d  = 1'b0;
        data_out_d = data_out_q;
        if (bypass) begin
            stb_out_d  = stb_in;
            data_out_d = data_in;
        end else if (!run) begin
            data_out_d = '0;
            overrun_d  = 1'b0;
            x0_d = '0;
            x1_d = '0;
            x2_d = '0;
            x3_d = '0;
            h0_d = '0;
            h1_d = '0;
        end else if (vld_q[4]) begin
            stb_out_d  = 1'b1;
            data_out_d = y0;
        end else if (vld_q[5]) begin
            stb_out_d  = 1'b1;
            data_out_d = yc_q[4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            x3_q       <= '0;
            h0_q       <= '0;
            h1_q       <= '0;
            sa_q       <= '0;
            sb_q       <= '0;
            yc_q       <= '0;
            vld_q      <= '0;
            pa_q       <= '0;
            p_q        <= '0;
            stb_out_q  <= 1'b0;
            data_out_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            x3_q       <= x3_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            yc_q       <= yc_d;
            vld_q      <= vld_d;
            pa_q       <= pa_d;
            p_q        <= p_d;
            stb_out_q  <= stb_out_d;
            data_out_q <= data_out_d;
            overrun_q  <= overrun_d;
        end
    end

    assign stb_out  = stb_out_q;
    assign data_out = data_out_q;
    assign overrun  = overrun_q;

endmodule
